stream_compare_sequencer: RTL and testbench
===========================================

Name: stream_compare_sequencer

Overview:
Run controller placed in front of the two-stream comparator.
- Clears the comparator and gates both input streams' TVALID so that exactly a programmed number of beat pairs reaches it.
- Latches the comparator's word/error counters and reports done/pass.
- Turns the free-running comparator into a bounded, repeatable test run, with timeout and abort.

Parameters:
CNT_WIDTH, 32, width of run length, threshold, timeout, counters
CLEAR_CYCLES, 4, cycles cmp_reset is held high at run start (>=1)
SETTLE_CYCLES, 2, comparator pipeline depth; wait after last gated pair and after latch pulse (>=1)

Ports:
clk  in  1  IP clock
aresetn  in  1  asynchronous active-low reset
start  in  1  single-cycle run request
abort  in  1  level/pulse; ends an active run
run_length  in  CNT_WIDTH  pairs to pass; 0 = continuous until abort/timeout
err_threshold  in  CNT_WIDTH  max error count still reported as pass
timeout  in  CNT_WIDTH  max RUN cycles without a pair; 0 = disabled
s0_tvalid  in  1  stream 0 TVALID (TDATA routed directly to comparator)
s1_tvalid  in  1  stream 1 TVALID
g0_tvalid  out  1  gated TVALID to comparator port 0
g1_tvalid  out  1  gated TVALID to comparator port 1
cmp_reset  out  1  comparator counter clear
cmp_latch  out  1  comparator counter latch request
cmp_word_count  in  CNT_WIDTH  comparator latched word count
cmp_err_count  in  CNT_WIDTH  comparator latched error count
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at run completion
pass  out  1  sticky result, valid from done until next start
timed_out  out  1  sticky flag
aborted  out  1  sticky flag
result_words  out  CNT_WIDTH  captured cmp_word_count
result_errs  out  CNT_WIDTH  captured cmp_err_count

Behaviour:
Reset:
- All outputs 0; state IDLE.
- Reset mid-run returns to IDLE immediately; results are cleared.

State machine:
- IDLE:
  - start=1 and abort=0: snapshot run_length/err_threshold/timeout into internal registers; clear pair_cnt, idle_cnt, sticky flags and results; go to CLEAR.
  - start and abort in the same cycle: stay IDLE.
- CLEAR:
  - cmp_reset=1 for exactly CLEAR_CYCLES cycles, then RUN.
  - abort here: set aborted, go to DRAIN.
- RUN:
  - pair = s0_tvalid & s1_tvalid.
  - g0_tvalid = g1_tvalid = pair (combinational, RUN only; 0 in all other states). Lone valids are never forwarded.
  - Each pair: pair_cnt+1 (saturates at all-ones), idle_cnt cleared.
  - No pair: idle_cnt+1.
  - Exit to DRAIN on the first of:
    - pair accepted while pair_cnt==run_length-1 (run_length!=0); that pair is forwarded.
    - abort: set aborted; a pair in the same cycle is not forwarded.
    - timeout!=0 and idle_cnt==timeout-1 with no pair: set timed_out.
  - abort has priority over completion and timeout in the same cycle.
- DRAIN: wait SETTLE_CYCLES, then LATCH.
- LATCH: cmp_latch=1 for one cycle, wait SETTLE_CYCLES, then go to REPORT.
- REPORT (one cycle):
  - result_words<=cmp_word_count, result_errs<=cmp_err_count.
  - pass<=!aborted & !timed_out & (cmp_err_count<=err_threshold) & (run_length==0 | cmp_word_count==run_length).
  - done=1; next IDLE.

Rules:
- start while busy: ignored.
- abort in DRAIN/LATCH/REPORT: ignored.
- Inputs changing mid-run: no effect (snapshotted).
- Counters are unsigned CNT_WIDTH.
- Run latency with no stalls and run_length=N: start -> done = 1+CLEAR_CYCLES+N+SETTLE_CYCLES+1+SETTLE_CYCLES+1 cycles.

Decomposition:
- Package stream_compare_pkg holds:
  - state enum seq_state_t (IDLE, CLEAR, RUN, DRAIN, LATCH, REPORT);
  - struct seq_cfg_t (run_length, err_threshold, timeout);
  - struct seq_status_t (busy, done, pass, timed_out, aborted, result_words, result_errs). Used later for register mapping.
- One sub-module, seq_wait_counter: load/decrement/zero-flag counter shared by the CLEAR, DRAIN and LATCH waits.

Test Plan:
1. run_length=8, threshold=0, both valids continuous, comparator reports 8/0 -> cmp_reset high 4 cycles, exactly 8 gated pairs, one cmp_latch pulse, done with pass=1, result_words=8.
2. run_length=8, threshold=1, comparator reports 8 words/2 errors -> pass=0, result_errs=2; rerun with threshold=2 -> pass=1.
3. s0 valid every cycle, s1 valid every 3rd cycle, run_length=5 -> g0/g1 high only on coincident cycles, exactly 5 pulses, done.
4. timeout=10, run_length=100, valids stop after 3 pairs -> DRAIN after 10 idle cycles; timed_out=1, pass=0, result_words=3.
5. run_length=0, abort asserted after 20 pairs (same cycle as a pair) -> pair not forwarded; aborted=1, pass=0, result_words=20.
6. start pulsed while busy, start+abort together in IDLE, aresetn dropped in RUN -> first two ignored; reset forces IDLE with all outputs 0 asynchronously.

Source files
------------

// File: rtl/stream_compare_pkg.sv
// stream_compare_pkg: shared types for the stream compare run sequencer
package stream_compare_pkg;
  localparam int SEQ_CNT_W = 32;
  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, LATCH, REPORT} seq_state_t;
  typedef struct packed {
    logic [SEQ_CNT_W-1:0] run_length;
    logic [SEQ_CNT_W-1:0] err_threshold;
    logic [SEQ_CNT_W-1:0] timeout;
  } seq_cfg_t;
  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic                 timed_out;
    logic                 aborted;
    logic [SEQ_CNT_W-1:0] result_words;
    logic [SEQ_CNT_W-1:0] result_errs;
  } seq_status_t;
endpackage

// File: rtl/seq_wait_counter.sv
// seq_wait_counter: loadable down-counter with zero flag for the sequencer waits
module seq_wait_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         aresetn,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         zero
);
  assign zero = cnt == '0;
  // load wins over decrement; the count parks at zero
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && !zero) cnt <= cnt - W'(1);
  end
endmodule

// File: rtl/stream_compare_sequencer.sv
// stream_compare_sequencer: bounded, repeatable run controller for the two-stream comparator
module stream_compare_sequencer
  import stream_compare_pkg::*;
#(
  parameter int CNT_WIDTH     = 32,
  parameter int CLEAR_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CNT_WIDTH-1:0] run_length,
  input  logic [CNT_WIDTH-1:0] err_threshold,
  input  logic [CNT_WIDTH-1:0] timeout,
  input  logic                 s0_tvalid,
  input  logic                 s1_tvalid,
  output logic                 g0_tvalid,
  output logic                 g1_tvalid,
  output logic                 cmp_reset,
  output logic                 cmp_latch,
  input  logic [CNT_WIDTH-1:0] cmp_word_count,
  input  logic [CNT_WIDTH-1:0] cmp_err_count,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timed_out,
  output logic                 aborted,
  output logic [CNT_WIDTH-1:0] result_words,
  output logic [CNT_WIDTH-1:0] result_errs
);
  localparam int WAIT_MAX = CLEAR_CYCLES > SETTLE_CYCLES ? CLEAR_CYCLES : SETTLE_CYCLES;
  localparam int WAIT_W = $clog2(WAIT_MAX + 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  localparam logic [WAIT_W-1:0] CLEAR_LOAD = WAIT_W'(CLEAR_CYCLES - 1);
  localparam logic [WAIT_W-1:0] SETTLE_LOAD = WAIT_W'(SETTLE_CYCLES - 1);
  localparam logic [WAIT_W-1:0] LATCH_LOAD = WAIT_W'(SETTLE_CYCLES);
  seq_state_t state_q, state_d;
  logic [CNT_WIDTH-1:0] cfg_len, cfg_thr, cfg_to;
  logic [CNT_WIDTH-1:0] pair_cnt, idle_cnt;
  logic [WAIT_W-1:0] w_val, w_cnt;
  logic w_load, w_dec, w_zero;
  logic launch, in_run, pair, fwd, last_pair, idle_hit, stop_abort, capture;
  assign launch     = (state_q == IDLE) && start && !abort;
  assign in_run     = state_q == RUN;
  assign pair       = s0_tvalid && s1_tvalid;
  assign fwd        = in_run && pair && !abort;
  assign last_pair  = fwd && (cfg_len != '0) && (pair_cnt == cfg_len - ONE);
  assign idle_hit   = in_run && !pair && (cfg_to != '0) && (idle_cnt == cfg_to - ONE);
  assign stop_abort = abort && ((state_q == CLEAR) || in_run);
  assign capture    = (state_q == LATCH) && w_zero;
  assign g0_tvalid  = fwd;
  assign g1_tvalid  = fwd;
  assign busy       = state_q != IDLE;
  assign cmp_reset  = state_q == CLEAR;
  assign cmp_latch  = (state_q == LATCH) && (w_cnt == LATCH_LOAD);
  assign done       = state_q == REPORT;
  seq_wait_counter #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .aresetn  (aresetn),
    .load     (w_load),
    .dec      (w_dec),
    .load_val (w_val),
    .cnt      (w_cnt),
    .zero     (w_zero)
  );
  // state register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else state_q <= state_d;
  end
  // next state and wait-counter control; abort outranks completion and timeout
  always_comb begin
    state_d = state_q;
    w_load  = 1'b0;
    w_dec   = 1'b0;
    w_val   = '0;
    case (state_q)
      IDLE: if (launch) begin
        state_d = CLEAR;
        w_load  = 1'b1;
        w_val   = CLEAR_LOAD;
      end
      CLEAR: if (abort) begin
        state_d = DRAIN;
        w_load  = 1'b1;
        w_val   = SETTLE_LOAD;
      end else if (w_zero) state_d = RUN;
      else w_dec = 1'b1;
      RUN: if (abort || last_pair || idle_hit) begin
        state_d = DRAIN;
        w_load  = 1'b1;
        w_val   = SETTLE_LOAD;
      end
      DRAIN: if (w_zero) begin
        state_d = LATCH;
        w_load  = 1'b1;
        w_val   = LATCH_LOAD;
      end else w_dec = 1'b1;
      LATCH: if (w_zero) state_d = REPORT;
      else w_dec = 1'b1;
      REPORT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // configuration snapshot and saturating pair/idle counters
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cfg_len  <= '0;
      cfg_thr  <= '0;
      cfg_to   <= '0;
      pair_cnt <= '0;
      idle_cnt <= '0;
    end else if (launch) begin
      cfg_len  <= run_length;
      cfg_thr  <= err_threshold;
      cfg_to   <= timeout;
      pair_cnt <= '0;
      idle_cnt <= '0;
    end else if (fwd) begin
      pair_cnt <= &pair_cnt ? pair_cnt : pair_cnt + ONE;
      idle_cnt <= '0;
    end else if (in_run) idle_cnt <= &idle_cnt ? idle_cnt : idle_cnt + ONE;
  end
  // sticky flags and results; results are taken on the last settle cycle so they are valid alongside done
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      timed_out    <= 1'b0;
      aborted      <= 1'b0;
      pass         <= 1'b0;
      result_words <= '0;
      result_errs  <= '0;
    end else if (launch) begin
      timed_out    <= 1'b0;
      aborted      <= 1'b0;
      pass         <= 1'b0;
      result_words <= '0;
      result_errs  <= '0;
    end else begin
      if (stop_abort) aborted <= 1'b1;
      if (idle_hit && !abort) timed_out <= 1'b1;
      if (capture) begin
        result_words <= cmp_word_count;
        result_errs  <= cmp_err_count;
        pass         <= !aborted && !timed_out && (cmp_err_count <= cfg_thr) &&
                        ((cfg_len == '0) || (cmp_word_count == cfg_len));
      end
    end
  end
endmodule

// File: tb/tb_stream_compare_sequencer.sv
// tb_stream_compare_sequencer: scoreboard bench with a cycle-list reference model
module tb_stream_compare_sequencer;
  localparam int W = 32;
  localparam int CLR = 4;
  localparam int SET = 2;
  localparam int MAXK = 400;
  typedef struct {
    logic [W-1:0] words;
    logic [W-1:0] errs;
    logic         pass;
    logic         tmo;
    logic         ab;
    int           lat;
  } exp_t;
  logic clk = 1'b0, aresetn = 1'b0, start = 1'b0, abort = 1'b0;
  logic s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic [W-1:0] run_length = '0, err_threshold = '0, timeout = '0;
  logic [W-1:0] cmp_word_count, cmp_err_count, result_words, result_errs;
  logic g0_tvalid, g1_tvalid, cmp_reset, cmp_latch, busy, done, pass, timed_out, aborted;
  logic [W-1:0] err_inj = '0, cmp_cnt;
  exp_t q[$];
  bit v0 [MAXK];
  bit v1 [MAXK];
  int n_tests = 0, n_fail = 0, cyc = 0, start_cyc = 0, done_cnt = 0;
  int pulses = 0, rst_cyc = 0, latch_n = 0, viol = 0;

  stream_compare_sequencer #(.CNT_WIDTH(W), .CLEAR_CYCLES(CLR), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .aresetn(aresetn), .start(start), .abort(abort),
    .run_length(run_length), .err_threshold(err_threshold), .timeout(timeout),
    .s0_tvalid(s0_tvalid), .s1_tvalid(s1_tvalid), .g0_tvalid(g0_tvalid), .g1_tvalid(g1_tvalid),
    .cmp_reset(cmp_reset), .cmp_latch(cmp_latch),
    .cmp_word_count(cmp_word_count), .cmp_err_count(cmp_err_count),
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out), .aborted(aborted),
    .result_words(result_words), .result_errs(result_errs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // comparator stand-in: counts gated pairs since clear, reports on latch
  always @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cmp_cnt        <= '0;
      cmp_word_count <= '0;
      cmp_err_count  <= '0;
    end else begin
      if (cmp_reset) cmp_cnt <= '0;
      else if (g0_tvalid && g1_tvalid) cmp_cnt <= cmp_cnt + 1;
      if (cmp_latch) begin
        cmp_word_count <= cmp_cnt;
        cmp_err_count  <= err_inj;
      end
    end
  end

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // kind 0: both always valid; 1: s1 every 3rd cycle; 2: prm pairs then s1 silent; 3: random, prob prm/4
  task automatic fill(input int kind, input int prm);
    for (int k = 0; k < MAXK; k++) begin
      case (kind)
        0: begin v0[k] = 1'b1; v1[k] = 1'b1; end
        1: begin v0[k] = 1'b1; v1[k] = (k % 3) == 2; end
        2: begin v0[k] = (k < prm) ? 1'b1 : 1'($urandom); v1[k] = k < prm; end
        default: begin v0[k] = $urandom_range(0, 3) < prm; v1[k] = $urandom_range(0, 3) < prm; end
      endcase
    end
  endtask

  // walk the RUN-cycle list applying the run rules; forces an abort if nothing else ends the run
  task automatic model(input logic [W-1:0] len, input logic [W-1:0] thr, input logic [W-1:0] to,
                       input logic [W-1:0] errs, inout int ab_at, output exp_t e, output int kend);
    int words, idle;
    bit ab, tmo, fin;
    words = 0; idle = 0; ab = 0; tmo = 0; fin = 0; kend = MAXK - 1;
    for (int k = 0; k < MAXK && !fin; k++) begin
      if (k == MAXK - 1) ab_at = k;
      if (k == ab_at) begin ab = 1; fin = 1; end
      else if (v0[k] && v1[k]) begin
        words++;
        idle = 0;
        if (len != 0 && words == len) fin = 1;
      end else begin
        idle++;
        if (to != 0 && idle == to) begin tmo = 1; fin = 1; end
      end
      if (fin) kend = k;
    end
    e.words = W'(words);
    e.errs  = errs;
    e.ab    = ab;
    e.tmo   = tmo;
    e.pass  = !ab && !tmo && (errs <= thr) && (len == 0 || W'(words) == len);
    e.lat   = 1 + CLR + (kend + 1) + SET + 1 + SET + 1;
  endtask

  task automatic run_case(input logic [W-1:0] len, input logic [W-1:0] thr, input logic [W-1:0] to,
                          input logic [W-1:0] errs, input int ab_in);
    exp_t e;
    int kend, ab_at, d0, n;
    ab_at = ab_in;
    model(len, thr, to, errs, ab_at, e, kend);
    q.push_back(e);
    err_inj = errs;
    run_length = len; err_threshold = thr; timeout = to;
    start = 1'b1; abort = 1'b0; start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    run_length = $urandom; err_threshold = $urandom; timeout = $urandom;
    for (int i = 0; i < CLR; i++) begin
      s0_tvalid = 1'($urandom); s1_tvalid = 1'($urandom); start = $urandom_range(0, 3) == 0;
      @(posedge clk); #1;
    end
    for (int k = 0; k <= kend; k++) begin
      s0_tvalid = v0[k]; s1_tvalid = v1[k]; abort = k == ab_at; start = $urandom_range(0, 3) == 0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      abort = 1'($urandom); s0_tvalid = 1'($urandom); s1_tvalid = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    abort = 1'b0; s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    if (done_cnt == d0) begin
      n_tests++;
      n_fail++;
      $display("FAIL done_timeout: got no done in %0d cycles expected one", n);
      q.delete();
    end
  endtask

  // monitor: per-run activity counters and scoreboard compare on done
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        pulses = 0; rst_cyc = 0; latch_n = 0; viol = 0;
      end else begin
        if (cmp_reset) rst_cyc++;
        if (cmp_latch) latch_n++;
        if (g0_tvalid) pulses++;
        if (g0_tvalid !== g1_tvalid || (g0_tvalid && !(s0_tvalid && s1_tvalid))) viol++;
        if (done) begin
          done_cnt++;
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got done=1 expected no run pending");
          end else begin
            e = q.pop_front();
            check("result_words", result_words, e.words);
            check("result_errs", result_errs, e.errs);
            check("pass", W'(pass), W'(e.pass));
            check("timed_out", W'(timed_out), W'(e.tmo));
            check("aborted", W'(aborted), W'(e.ab));
            check("gated_pairs", W'(pulses), e.words);
            check("cmp_reset_cycles", W'(rst_cyc), W'(CLR));
            check("latch_pulses", W'(latch_n), W'(1));
            check("gate_violations", W'(viol), W'(0));
            check("latency", W'(cyc - start_cyc + 1), W'(e.lat));
          end
          pulses = 0; rst_cyc = 0; latch_n = 0; viol = 0;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", W'({busy, done, pass, timed_out, aborted, g0_tvalid, g1_tvalid, cmp_reset, cmp_latch}), W'(0));
    check("reset_words", result_words, W'(0));
    check("reset_errs", result_errs, W'(0));
    aresetn = 1'b1;
    @(posedge clk); #1;
    fill(0, 0);
    run_case(8, 0, 0, 0, -1);
    repeat (3) @(posedge clk);
    #1;
    check("pass_sticky", W'(pass), W'(1));
    check("words_sticky", result_words, W'(8));
    fill(0, 0);
    run_case(8, 1, 0, 2, -1);
    run_case(8, 2, 0, 2, -1);
    fill(1, 0);
    run_case(5, 0, 0, 0, -1);
    fill(2, 3);
    run_case(100, 0, 10, 0, -1);
    fill(0, 0);
    run_case(0, 0, 0, 0, 20);
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("start_abort_idle_busy", W'(busy), W'(0));
    @(posedge clk); #1;
    check("start_abort_idle_clear", W'(cmp_reset), W'(0));
    run_length = 0; timeout = 0; err_threshold = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s0_tvalid = 1'b1; s1_tvalid = 1'b1;
    repeat (CLR + 3) @(posedge clk);
    #1;
    check("busy_in_run", W'(busy), W'(1));
    check("gate_in_run", W'(g0_tvalid), W'(1));
    #2;
    aresetn = 1'b0;
    #1;
    check("async_reset_flags", W'({busy, done, pass, timed_out, aborted, g0_tvalid, g1_tvalid, cmp_reset, cmp_latch}), W'(0));
    check("async_reset_words", result_words, W'(0));
    @(posedge clk); #1;
    aresetn = 1'b1; s0_tvalid = 1'b0; s1_tvalid = 1'b0;
    @(posedge clk); #1;
    check("after_reset_idle", W'(busy), W'(0));
    fill(0, 0);
    run_case(3, 0, 0, 0, -1);
    for (int r = 0; r < 20; r++) begin
      logic [W-1:0] len, to;
      int ab;
      fill(3, $urandom_range(1, 4));
      len = $urandom_range(0, 20);
      to = $urandom_range(0, 1) ? W'($urandom_range(1, 12)) : W'(0);
      ab = $urandom_range(0, 3) == 0 ? int'($urandom_range(0, 40)) : -1;
      if (len == 0 && to == 0 && ab < 0) ab = $urandom_range(5, 60);
      run_case(len, $urandom_range(0, 3), to, $urandom_range(0, 4), ab);
    end
    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", W'(q.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
